imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_byte_packer.sv | 26 ++
 rtl/imem_loader.sv | 91 +++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and frame constants for the instruction-memory loader.
package imem_loader_pkg;
  localparam int LEN_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: gathers little-endian bytes into 32-bit words; full flags the byte completing a word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        full,
  output logic [31:0] word
);
  logic [1:0] cnt;
  logic [8*(BYTES_PER_WORD-1)-1:0] part;
  assign full = en && cnt == 2'(BYTES_PER_WORD - 1);
  assign word = {din, part};
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      part <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      part <= {din, part[8*(BYTES_PER_WORD-1)-1:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte frame and writes it into instruction memory, holding the core in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);
  state_t state, nxt;
  logic [8*LEN_BYTES-1:0] len;
  logic [ADDR_W:0] idx;
  logic [16:0] n_words;
  logic [31:0] word;
  logic acc, full, last;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] sum;
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif
  assign busy = state != IDLE && state != DONE && state != ERR;
  assign in_ready = busy;
  assign err = state == ERR;
  assign cpu_rst_n = state == DONE;
  assign acc = in_valid && in_ready;
  assign n_words = {1'b0, in_data, len[7:0]};
  assign last = 17'(idx) + 17'd1 == {1'b0, len};
  imem_byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clr(state != DATA),
    .en(acc && state == DATA),
    .din(in_data),
    .full(full),
    .word(word)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN_LO : state;
      LEN_LO: nxt = acc ? LEN_HI : state;
      LEN_HI: nxt = !acc ? state : n_words > (17'd1 << ADDR_W) ? ERR : n_words == 17'd0 ? FIN : DATA;
      DATA: nxt = full && last ? FIN : state;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: nxt = !acc ? state : 8'(sum + in_data) == 8'd0 ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= nxt;
      imem_we <= full;
      if (full) begin
        imem_waddr <= idx[ADDR_W-1:0];
        imem_wdata <= word;
        idx <= idx + (ADDR_W+1)'(1);
      end
      if (acc && state == LEN_LO) len[7:0] <= in_data;
      if (acc && state == LEN_HI) len[15:8] <= in_data;
      if (state != LEN_LO && nxt == LEN_LO) idx <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      // running sum restarts with each new frame
      if (state != LEN_LO && nxt == LEN_LO) sum <= '0;
      else if (acc && state != CSUM) sum <= sum + in_data;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a byte-level frame model; a scoreboard checks every memory write.
module tb_imem_loader;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, imem_we, cpu_rst_n, busy, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  typedef struct {int a; logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [7:0] fr[$];
  int errors = 0, checks = 0, cyc = 0;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (imem_we) begin
      if (q.size() == 0) chk("spurious_we", imem_we, 1'b0);
      else begin
        e_m = q.pop_front();
        chk("waddr", 32'(imem_waddr), e_m.a);
        chk("wdata", imem_wdata, e_m.d);
        chk("wcycle", cyc, e_m.c);
      end
    end
  end

  task automatic add_csum();
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] s = 8'd0;
    foreach (fr[k]) s += fr[k];
    fr.push_back(8'(8'd0 - s));
`endif
  endtask

  task automatic build(int n);
    fr.delete();
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    if (n <= (1 << AW)) begin
      repeat (4 * n) fr.push_back(8'($urandom));
      add_csum();
    end
  endtask

  function automatic bit exp_err();
    int n = int'(fr[0]) | (int'(fr[1]) << 8);
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] s = 8'd0;
    foreach (fr[k]) s += fr[k];
    if (n <= (1 << AW)) return s != 8'd0;
`endif
    return n > (1 << AW);
  endfunction

  // vmode: 0 always valid, 1 toggling, 2 random; start_at pulses start alongside that byte index
  task automatic send(bit do_start, int vmode, int start_at);
    int i = 0, w = 0, n;
    bit v, tog = 1'b0, pulsed = 1'b0;
    n = int'(fr[0]) | (int'(fr[1]) << 8);
    if (do_start) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    while (i < fr.size()) begin
      @(negedge clk);
      start = i == start_at && !pulsed;
      if (start) pulsed = 1'b1;
      v = vmode == 0 ? 1'b1 : vmode == 1 ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      in_valid = v;
      in_data = fr[i];
      if (v && in_ready) begin
        if (i >= 2 && (i - 2) % 4 == 3 && (i - 2) / 4 < n)
          q.push_back('{(i - 2) / 4, {fr[i], fr[i-1], fr[i-2], fr[i-3]}, cyc + 1});
        i++;
        w = 0;
      end else if (++w > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %0d still not accepted after 100 cycles, want accepted", i);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic fin(bit e);
    int t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("busy_clear", busy, 1'b0);
    chk("err", err, e);
    chk("cpu_rst_n", cpu_rst_n, !e);
    chk("pending_writes", q.size(), 0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_imem_we"}, imem_we, 1'b0);
    chk({tag, "_waddr"}, 32'(imem_waddr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    add_csum();
    send(1'b1, 0, -1);
    fin(1'b0);
    chk("last_word_req036", imem_wdata, 32'h00100593);
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    add_csum();
    send(1'b1, 1, -1);
    fin(1'b0);
    fr = '{8'h01, 8'h04};
    send(1'b1, 0, -1);
    fin(1'b1);
    build(1 << AW);
    send(1'b1, 0, -1);
    fin(1'b0);
    build(0);
    send(1'b1, 2, -1);
    fin(exp_err());
    repeat (6) begin
      build($urandom_range(1, 6));
      send(1'b1, 2, -1);
      fin(exp_err());
    end
    build(3);
    send(1'b1, 0, 6);
    fin(1'b0);
    @(negedge clk);
    chk("done_cpu_rst_n", cpu_rst_n, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("restart_busy", busy, 1'b1);
    build(2);
    send(1'b0, 2, -1);
    fin(1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    build(2);
    fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    send(1'b1, 0, -1);
    fin(1'b1);
    build(2);
    send(1'b1, 2, -1);
    fin(1'b0);
`endif
    build(2);
    fr = fr[0:3];
    send(1'b1, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("after_rst");
    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
